// File: rtl/lsu_dual.sv
// rtl/lsu_dual.sv - dual-issue load/store unit with internal word memory
module lsu_dual #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_0,
   output logic              req_ready_0,
   input  logic              req_we_0,
   input  logic [ADDR_W-1:0] req_addr_0,
   input  logic [DATA_W-1:0] req_wdata_0,
   input  logic [DATA_W/8-1:0] req_be_0,
   output logic              resp_valid_0,
   output logic [DATA_W-1:0] resp_rdata_0,
   output logic              resp_err_0,
   input  logic              req_valid_1,
   output logic              req_ready_1,
   input  logic              req_we_1,
   input  logic [ADDR_W-1:0] req_addr_1,
   input  logic [DATA_W-1:0] req_wdata_1,
   input  logic [DATA_W/8-1:0] req_be_1,
   output logic              resp_valid_1,
   output logic [DATA_W-1:0] resp_rdata_1,
   output logic              resp_err_1,
   output logic [15:0]       stall_cnt
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              in_range_0, in_range_1, coalesce, acc_0, acc_1;
   logic [IDX_W-1:0]  idx_0, idx_1;

   logic              wr_en_d;
   logic [IDX_W-1:0]  wr_idx_d;
   logic [DATA_W-1:0] wr_word_d, sel_wdata;
   logic [BE_W-1:0]   sel_be;

   logic              resp_valid_0_q, resp_valid_0_d, resp_valid_1_q, resp_valid_1_d;
   logic              resp_err_0_q, resp_err_0_d, resp_err_1_q, resp_err_1_d;
   logic [DATA_W-1:0] resp_rdata_0_q, resp_rdata_0_d, resp_rdata_1_q, resp_rdata_1_d;
   logic [15:0]       stall_cnt_q, stall_cnt_d;

   // Issue arbitration: slot 0 always wins; slot 1 only rides along on an identical in-range load
   always_comb begin
      in_range_0  = req_addr_0 < DEPTH_A;
      in_range_1  = req_addr_1 < DEPTH_A;
      idx_0       = req_addr_0[IDX_W-1:0];
      idx_1       = req_addr_1[IDX_W-1:0];
      coalesce    = req_valid_0 & req_valid_1 & ~req_we_0 & ~req_we_1
                    & (req_addr_0 == req_addr_1) & in_range_0;
      req_ready_0 = ~rst;
      req_ready_1 = ~rst & (~req_valid_0 | coalesce);
      acc_0       = req_valid_0 & req_ready_0;
      acc_1       = req_valid_1 & req_ready_1;
   end

   // Single memory port: the accepted slot (slot 0 first) owns the write, merged per byte enable
   always_comb begin
      wr_en_d   = 1'b0;
      wr_idx_d  = idx_0;
      sel_wdata = req_wdata_0;
      sel_be    = req_be_0;
      if (acc_0) begin
         wr_en_d = req_we_0 & in_range_0;
      end else begin
         wr_en_d   = acc_1 & req_we_1 & in_range_1;
         wr_idx_d  = idx_1;
         sel_wdata = req_wdata_1;
         sel_be    = req_be_1;
      end
      wr_word_d = mem_q[wr_idx_d];
      for (int b = 0; b < BE_W; b++) begin
         if (sel_be[b]) wr_word_d[8*b +: 8] = sel_wdata[8*b +: 8];
      end
   end

   // Next response per slot; loads see memory before this cycle's store, stores and errors return zero
   always_comb begin
      resp_valid_0_d = acc_0;
      resp_valid_1_d = acc_1;
      resp_err_0_d   = acc_0 & ~in_range_0;
      resp_err_1_d   = acc_1 & ~in_range_1;
      resp_rdata_0_d = (acc_0 & ~req_we_0 & in_range_0) ? mem_q[idx_0] : '0;
      resp_rdata_1_d = (acc_1 & ~req_we_1 & in_range_1) ? mem_q[idx_1] : '0;
      stall_cnt_d    = stall_cnt_q;
      if (req_valid_1 & ~req_ready_1 & (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // State update; reset wipes memory and drops anything presented on the reset edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         resp_valid_0_q <= 1'b0;
         resp_valid_1_q <= 1'b0;
         resp_err_0_q   <= 1'b0;
         resp_err_1_q   <= 1'b0;
         resp_rdata_0_q <= '0;
         resp_rdata_1_q <= '0;
         stall_cnt_q    <= '0;
      end else begin
         if (wr_en_d) mem_q[wr_idx_d] <= wr_word_d;
         resp_valid_0_q <= resp_valid_0_d;
         resp_valid_1_q <= resp_valid_1_d;
         resp_err_0_q   <= resp_err_0_d;
         resp_err_1_q   <= resp_err_1_d;
         resp_rdata_0_q <= resp_rdata_0_d;
         resp_rdata_1_q <= resp_rdata_1_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign resp_valid_0 = resp_valid_0_q;
   assign resp_valid_1 = resp_valid_1_q;
   assign resp_err_0   = resp_err_0_q;
   assign resp_err_1   = resp_err_1_q;
   assign resp_rdata_0 = resp_rdata_0_q;
   assign resp_rdata_1 = resp_rdata_1_q;
   assign stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_lsu_dual.sv
// tb/tb_lsu_dual.sv - self-checking bench for lsu_dual
module tb_lsu_dual;
   localparam int DW = 32;
   localparam int DEPTH = 32;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst;
   logic req_valid_0, req_ready_0, req_we_0, resp_valid_0, resp_err_0;
   logic req_valid_1, req_ready_1, req_we_1, resp_valid_1, resp_err_1;
   logic [AW-1:0] req_addr_0, req_addr_1;
   logic [DW-1:0] req_wdata_0, req_wdata_1, resp_rdata_0, resp_rdata_1;
   logic [3:0] req_be_0, req_be_1;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] m_mem [DEPTH];
   logic [15:0] m_stall;

   logic o_rdy0, o_rdy1, o_rv0, o_rv1, o_err0, o_err1;
   logic [DW-1:0] o_rd0, o_rd1;
   logic [15:0] o_stall;
   logic e_rdy0, e_rdy1, e_rv0, e_rv1, e_err0, e_err1;
   logic [DW-1:0] e_rd0, e_rd1;
   logic [15:0] e_stall;

   always #5 clk = ~clk;

   lsu_dual #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
      .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0), .req_be_0(req_be_0),
      .resp_valid_0(resp_valid_0), .resp_rdata_0(resp_rdata_0), .resp_err_0(resp_err_0),
      .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
      .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1), .req_be_1(req_be_1),
      .resp_valid_1(resp_valid_1), .resp_rdata_1(resp_rdata_1), .resp_err_1(resp_err_1),
      .stall_cnt(stall_cnt)
   );

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_stall = '0;
   endtask

   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      for (int b = 0; b < 4; b++) if (be[b]) m_mem[a[4:0]][8*b +: 8] = d[8*b +: 8];
   endtask

   // Reference behaviour for the request pair currently on the inputs
   task automatic model_eval();
      logic coal;
      coal = req_valid_0 && req_valid_1 && !req_we_0 && !req_we_1
             && (req_addr_0 == req_addr_1) && (req_addr_0 < DEPTH);
      e_rdy0 = 1'b1;
      e_rdy1 = !req_valid_0 || coal;
      e_rv0  = req_valid_0;
      e_rv1  = req_valid_1 && e_rdy1;
      e_err0 = e_rv0 && (req_addr_0 >= DEPTH);
      e_err1 = e_rv1 && (req_addr_1 >= DEPTH);
      e_rd0  = (e_rv0 && !req_we_0 && req_addr_0 < DEPTH) ? m_mem[req_addr_0[4:0]] : '0;
      e_rd1  = (e_rv1 && !req_we_1 && req_addr_1 < DEPTH) ? m_mem[req_addr_1[4:0]] : '0;
      if (req_valid_1 && !e_rdy1 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      e_stall = m_stall;
      if (e_rv0 && req_we_0 && req_addr_0 < DEPTH) model_write(req_addr_0, req_wdata_0, req_be_0);
      else if (e_rv1 && req_we_1 && req_addr_1 < DEPTH) model_write(req_addr_1, req_wdata_1, req_be_1);
   endtask

   task automatic step(input logic v0, input logic we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic [3:0] be0,
                       input logic v1, input logic we1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [3:0] be1);
      @(negedge clk);
      req_valid_0 = v0; req_we_0 = we0; req_addr_0 = a0; req_wdata_0 = d0; req_be_0 = be0;
      req_valid_1 = v1; req_we_1 = we1; req_addr_1 = a1; req_wdata_1 = d1; req_be_1 = be1;
      #1;
      o_rdy0 = req_ready_0;
      o_rdy1 = req_ready_1;
      model_eval();
      @(posedge clk);
      #1;
      o_rv0 = resp_valid_0; o_rd0 = resp_rdata_0; o_err0 = resp_err_0;
      o_rv1 = resp_valid_1; o_rd1 = resp_rdata_1; o_err1 = resp_err_1;
      o_stall = stall_cnt;
      req_valid_0 = 1'b0;
      req_valid_1 = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0);
   endtask

   task automatic load0(input logic [AW-1:0] a);
      step(1'b1, 1'b0, a, '0, 4'h0, 1'b0, 1'b0, '0, '0, 4'h0);
   endtask

   task automatic store0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      step(1'b1, 1'b1, a, d, be, 1'b0, 1'b0, '0, '0, 4'h0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      req_we_0 = 1'b0; req_we_1 = 1'b0; req_addr_0 = '0; req_addr_1 = '0;
      req_wdata_0 = '0; req_wdata_1 = '0; req_be_0 = '0; req_be_1 = '0;
      @(posedge clk); #1;
      n_cmp++;
      if ({req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_err_0, resp_err_1,
           resp_rdata_0, resp_rdata_1, stall_cnt} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: rdy=%b%b rv=%b%b err=%b%b rd0=%h rd1=%h stall=%0d, required all zero",
                  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_err_0, resp_err_1,
                  resp_rdata_0, resp_rdata_1, stall_cnt);
      end
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_load_basic();
      load0(32'd5);
      n_cmp++;
      if ({o_rdy0, o_rv0, o_err0, o_rd0} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL load5: rdy=%b rv=%b err=%b rd=%h, required 1 1 0 00000000", o_rdy0, o_rv0, o_err0, o_rd0);
      end
      idle();
      n_cmp++;
      if (o_rv0 !== 1'b0) begin
         n_bad++;
         $display("FAIL resp_one_cycle: rv0=%b, required 0", o_rv0);
      end
   endtask

   task automatic test_store_load();
      store0(32'd3, 32'hDEADBEEF, 4'hF);
      n_cmp++;
      if ({o_rv0, o_err0, o_rd0} !== {1'b1, 1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL store3_resp: rv=%b err=%b rd=%h, required 1 0 00000000", o_rv0, o_err0, o_rd0);
      end
      load0(32'd3);
      n_cmp++;
      if ({o_rv0, o_rd0} !== {1'b1, 32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL load3: rv=%b rd=%h, required 1 deadbeef", o_rv0, o_rd0);
      end
   endtask

   task automatic test_be_merge();
      store0(32'd3, 32'h11223344, 4'b0101);
      load0(32'd3);
      n_cmp++;
      if (o_rd0 !== 32'hDE22BE44) begin
         n_bad++;
         $display("FAIL be_merge: rd=%h, required de22be44", o_rd0);
      end
      store0(32'd3, 32'hFFFFFFFF, 4'b0000);
      n_cmp++;
      if (o_rv0 !== 1'b1) begin
         n_bad++;
         $display("FAIL be0_resp: rv=%b, required 1", o_rv0);
      end
      load0(32'd3);
      n_cmp++;
      if (o_rd0 !== 32'hDE22BE44) begin
         n_bad++;
         $display("FAIL be0_noop: rd=%h, required de22be44", o_rd0);
      end
   endtask

   task automatic test_hazard();
      step(1'b1, 1'b1, 32'd7, 32'hA5A55A5A, 4'hF, 1'b1, 1'b0, 32'd7, '0, 4'h0);
      n_cmp++;
      if ({o_rdy1, o_rv1, o_stall} !== {1'b0, 1'b0, 16'd1}) begin
         n_bad++;
         $display("FAIL hazard_stall: rdy1=%b rv1=%b stall=%0d, required 0 0 1", o_rdy1, o_rv1, o_stall);
      end
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b0, 32'd7, '0, 4'h0);
      n_cmp++;
      if ({o_rdy1, o_rv1, o_rd1} !== {1'b1, 1'b1, 32'hA5A55A5A}) begin
         n_bad++;
         $display("FAIL hazard_load1: rdy1=%b rv1=%b rd1=%h, required 1 1 a5a55a5a", o_rdy1, o_rv1, o_rd1);
      end
   endtask

   task automatic test_coalesce();
      store0(32'd9, 32'h0BADF00D, 4'hF);
      step(1'b1, 1'b0, 32'd9, '0, 4'h0, 1'b1, 1'b0, 32'd9, '0, 4'h0);
      n_cmp++;
      if ({o_rdy0, o_rdy1, o_rv0, o_rv1, o_rd0, o_rd1, o_stall} !==
          {1'b1, 1'b1, 1'b1, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 16'd1}) begin
         n_bad++;
         $display("FAIL coalesce: rdy=%b%b rv=%b%b rd0=%h rd1=%h stall=%0d, required 11 11 0badf00d 0badf00d 1",
                  o_rdy0, o_rdy1, o_rv0, o_rv1, o_rd0, o_rd1, o_stall);
      end
   endtask

   task automatic test_out_of_range();
      load0(32'd40);
      n_cmp++;
      if ({o_rv0, o_err0, o_rd0} !== {1'b1, 1'b1, 32'h0}) begin
         n_bad++;
         $display("FAIL oor_load: rv=%b err=%b rd=%h, required 1 1 00000000", o_rv0, o_err0, o_rd0);
      end
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 1'b1, 32'd40, 32'h12345678, 4'hF);
      n_cmp++;
      if ({o_rv1, o_err1, o_rd1} !== {1'b1, 1'b1, 32'h0}) begin
         n_bad++;
         $display("FAIL oor_store1: rv=%b err=%b rd=%h, required 1 1 00000000", o_rv1, o_err1, o_rd1);
      end
      load0(32'd8);
      n_cmp++;
      if ({o_err0, o_rd0} !== {1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL oor_no_alias: err=%b rd=%h, required 0 00000000", o_err0, o_rd0);
      end
   endtask

   task automatic test_random();
      logic v0, v1, we0, we1;
      logic [AW-1:0] a0, a1;
      for (int i = 0; i < 400; i++) begin
         v0  = ($urandom_range(0, 3) != 0);
         v1  = ($urandom_range(0, 2) != 0);
         we0 = $urandom_range(0, 1) == 1;
         we1 = $urandom_range(0, 1) == 1;
         a0  = 32'($urandom_range(0, 39));
         a1  = ($urandom_range(0, 2) == 0) ? a0 : 32'($urandom_range(0, 39));
         step(v0, we0, a0, 32'($urandom), 4'($urandom), v1, we1, a1, 32'($urandom), 4'($urandom));
         n_cmp++;
         if ({o_rdy0, o_rdy1, o_rv0, o_rv1, o_err0, o_err1, o_rd0, o_rd1, o_stall} !==
             {e_rdy0, e_rdy1, e_rv0, e_rv1, e_err0, e_err1, e_rd0, e_rd1, e_stall}) begin
            n_bad++;
            $display("FAIL random[%0d]: rdy=%b%b rv=%b%b err=%b%b rd0=%h rd1=%h st=%0d, required rdy=%b%b rv=%b%b err=%b%b rd0=%h rd1=%h st=%0d",
                     i, o_rdy0, o_rdy1, o_rv0, o_rv1, o_err0, o_err1, o_rd0, o_rd1, o_stall,
                     e_rdy0, e_rdy1, e_rv0, e_rv1, e_err0, e_err1, e_rd0, e_rd1, e_stall);
         end
      end
   endtask

   task automatic test_saturate();
      @(negedge clk);
      req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = '0; req_be_0 = 4'h0;
      req_valid_1 = 1'b1; req_we_1 = 1'b0; req_addr_1 = '0;
      repeat (65540) @(posedge clk);
      @(negedge clk);
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      #1;
      m_stall = 16'hFFFF;
      n_cmp++;
      if (stall_cnt !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL stall_saturate: stall=%h, required ffff", stall_cnt);
      end
   endtask

   task automatic test_reset_mid();
      store0(32'd40, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 32'd2;
      req_wdata_0 = 32'hFFFFFFFF; req_be_0 = 4'hF;
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({resp_valid_0, resp_valid_1, stall_cnt} !== {1'b0, 1'b0, 16'd0}) begin
         n_bad++;
         $display("FAIL reset_mid: rv=%b%b stall=%0d, required 00 0", resp_valid_0, resp_valid_1, stall_cnt);
      end
      req_valid_0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      for (int a = 0; a < DEPTH; a++) begin
         load0(AW'(a));
         n_cmp++;
         if ({o_rv0, o_rd0} !== {1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL mem_cleared[%0d]: rv=%b rd=%h, required 1 00000000", a, o_rv0, o_rd0);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid_0 = 1'b0; req_valid_1 = 1'b0;
      req_we_0 = 1'b0; req_we_1 = 1'b0; req_addr_0 = '0; req_addr_1 = '0;
      req_wdata_0 = '0; req_wdata_1 = '0; req_be_0 = '0; req_be_1 = '0;
      model_clear();
      test_reset();
      test_load_basic();
      test_store_load();
      test_be_merge();
      test_hazard();
      test_coalesce();
      test_out_of_range();
      test_random();
      test_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lsu_dual.md
LSU_DUAL -- requirements
Module: lsu_dual

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 32: number of words in the internal data memory; power of two, ≥2.
REQ-003 SHALL have parameter ADDR_W, default 32: request address width; word-addressed.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have, for each issue slot p in {0,1}, port req_valid_p, input, 1: request present.
REQ-007 SHALL have, for each issue slot p in {0,1}, port req_ready_p, output, 1: request accepted this cycle when high with req_valid_p.
REQ-008 SHALL have, for each issue slot p in {0,1}, port req_we_p, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have, for each issue slot p in {0,1}, port req_addr_p, input, ADDR_W: word address.
REQ-010 SHALL have, for each issue slot p in {0,1}, port req_wdata_p, input, DATA_W: store data.
REQ-011 SHALL have, for each issue slot p in {0,1}, port req_be_p, input, DATA_W/8: store byte enables; bit i covers bits 8i+7:8i.
REQ-012 SHALL have, for each issue slot p in {0,1}, port resp_valid_p, output, 1: single-cycle response strobe.
REQ-013 SHALL have, for each issue slot p in {0,1}, port resp_rdata_p, output, DATA_W: load data.
REQ-014 SHALL have, for each issue slot p in {0,1}, port resp_err_p, output, 1: address out of range.
REQ-015 SHALL have port stall_cnt, output, 16: saturating count of slot-1 stall cycles.

Function
REQ-016 SHALL hold DEPTH x DATA_W words internally; no external memory port.
REQ-017 SHALL treat slot 0 as older in program order; slot 1 SHALL never complete ahead of a pending slot-0 request.
REQ-018 SHALL drive req_ready_0 = 1 whenever not in reset.
REQ-019 SHALL drive req_ready_1 = !req_valid_0 OR coalesce, where coalesce = both valid, both loads, equal addresses, and address < DEPTH.
REQ-020 SHALL perform at most one memory access per cycle; a coalesced pair counts as one access.
REQ-021 SHALL treat an address ≥ DEPTH as an error: accepted, no memory change, resp_err_p = 1, resp_rdata_p = 0.
REQ-022 SHALL, on a store, update each byte whose req_be bit = 1 and leave the other bytes unchanged.
REQ-023 SHALL treat a store with be = 0 as a legal no-op that still responds.
REQ-024 SHALL, on acceptance in cycle N, assert resp_valid_p in cycle N+1 for exactly one cycle.
REQ-025 SHALL, for a load, present the memory word as it was before any store accepted in cycle N on resp_rdata_p, valid with resp_valid_p.
REQ-026 SHALL, for a store response, drive resp_rdata_p = 0.
REQ-027 SHALL have no response backpressure; responses cannot be stalled.
REQ-028 SHALL, when resp_valid_p = 0, drive resp_rdata_p = 0 and resp_err_p = 0.
REQ-029 SHALL guarantee that a load accepted in the cycle after a store to the same address returns the stored data; no forwarding is needed because accesses are serialised.
REQ-030 SHALL make back-to-back accepted requests on a slot in consecutive cycles yield consecutive response strobes.
REQ-031 SHALL increment stall_cnt by 1 in each cycle where req_valid_1 = 1 and req_ready_1 = 0.
REQ-032 SHALL saturate stall_cnt at 16'hFFFF and never wrap.
REQ-033 SHALL reach no state that prevents slot 1 from being accepted once req_valid_0 is deasserted.

Reset
REQ-034 SHALL, while rst = 1 (asynchronous, active-high): drive req_ready_0 = 0, req_ready_1 = 0, all resp_valid_p = 0, all resp_rdata_p = 0, all resp_err_p = 0, and stall_cnt = 0; all memory words SHALL be cleared to 0.
REQ-035 SHALL discard any request accepted in the cycle rst asserts (reset mid-operation); no response and no memory write SHALL result.
REQ-036 SHALL accept requests from the first rising edge after rst deasserts.

Verification
REQ-037 SHALL cover: reset, then slot 0 load addr 5 -> resp_valid_0 next cycle, rdata 0, err 0.
REQ-038 SHALL cover: slot 0 store addr 3 data 32'hDEADBEEF be 4'b1111, then load addr 3 -> rdata 32'hDEADBEEF exactly 1 cycle after load acceptance.
REQ-039 SHALL cover: byte-enable merge -> store 32'h11223344 be 4'b0101 over 32'hDEADBEEF -> load returns 32'hDE22BE44.
REQ-040 SHALL cover: slot 0 store addr 7 and slot 1 load addr 7 in the same cycle -> req_ready_1 = 0, stall_cnt = 1; slot 1 accepted next cycle and returns the stored data.
REQ-041 SHALL cover: coalesced loads, both slots load addr 9 in the same cycle -> both ready, both resp_valid next cycle with identical data, stall_cnt unchanged.
REQ-042 SHALL cover: out-of-range and reset, load addr 40 (DEPTH = 32) -> resp_err = 1, rdata 0; store addr 40, then rst pulse mid-stream -> no response, memory all 0, stall_cnt = 0.
